// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter on open-drain ps2c/ps2d.
// Define PS2_TX_ACK_CHECK_EN to register the device ack bit onto ack_err.
module ps2_tx #(
    parameter int RTS_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int CW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [7:0]    filter_reg;
    logic [7:0]    filter_next;
    logic          f_val_reg;
    logic          f_val_next;
    logic          fall_edge;

    logic [8:0]    b_reg, b_next;
    logic [3:0]    n_reg, n_next;
    logic [CW-1:0] c_reg, c_next;
    logic          cz_reg, dz_reg;

    // Glitch filter: the clock level only flips after 8 agreeing samples
    assign filter_next = {ps2c, filter_reg[7:1]};
    assign f_val_next  = (filter_next == 8'hFF) ? 1'b1 :
                         (filter_next == 8'h00) ? 1'b0 : f_val_reg;
    assign fall_edge   = f_val_reg & ~f_val_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            filter_reg <= '0;
            f_val_reg  <= 1'b0;
            b_reg      <= '0;
            n_reg      <= '0;
            c_reg      <= '0;
            cz_reg     <= 1'b0;
            dz_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            filter_reg <= filter_next;
            f_val_reg  <= f_val_next;
            b_reg      <= b_next;
            n_reg      <= n_next;
            c_reg      <= c_next;
            cz_reg     <= (state_reg == S_RTS);
            dz_reg     <= (state_reg == S_START) |
                          ((state_reg == S_DATA) & ~b_reg[0]);
        end
    end

    always_comb begin
        state_next   = state_reg;
        b_next       = b_reg;
        n_next       = n_reg;
        c_next       = c_reg;
        tx_done_tick = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (wr_ps2) begin
                    b_next     = {~^din, din};
                    c_next     = CW'(RTS_CYCLES - 1);
                    state_next = S_RTS;
                end
            end
            S_RTS: begin
                if (c_reg == '0)
                    state_next = S_START;
                else
                    c_next = c_reg - CW'(1);
            end
            S_START: begin
                if (fall_edge) begin
                    n_next     = 4'd8;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (fall_edge) begin
                    b_next = {1'b0, b_reg[8:1]};
                    if (n_reg == 4'd0)
                        state_next = S_STOP;
                    else
                        n_next = n_reg - 4'd1;
                end
            end
            S_STOP: begin
                if (fall_edge)
                    state_next = S_DONE;
            end
            S_DONE: begin
                if (f_val_reg) begin
                    tx_done_tick = 1'b1;
                    state_next   = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef PS2_TX_ACK_CHECK_EN
    logic ack_reg;

    // Device pulls ps2d low to acknowledge; a high line means no ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ack_reg <= 1'b0;
        else if ((state_reg == S_STOP) && fall_edge)
            ack_reg <= ps2d;
    end

    assign ack_err = ack_reg;
`else
    assign ack_err = 1'b0;
`endif

    assign tx_idle = (state_reg == S_IDLE);
    assign ps2c    = cz_reg ? 1'b0 : 1'bz;
    assign ps2d    = dz_reg ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: device model plus scoreboard for the PS/2 host transmitter.
// Expected frames are {stop, parity, din, start}, bit 0 on the wire first.
module tb_ps2_tx;

    localparam int RTS  = 50;
    localparam int HALF = 40;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam logic ACK_CHK = 1'b1;
`else
    localparam logic ACK_CHK = 1'b0;
`endif

    typedef struct {
        logic [10:0] frame;
        logic        ack;
    } exp_t;

    typedef struct {
        logic [10:0] frame;
        int          rts;
    } cap_t;

    exp_t sb_q[$];
    cap_t cap_q[$];

    int compared = 0;
    int mism     = 0;
    int n_ticks  = 0;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din    = 8'h00;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;

    logic dev_c_low  = 1'b0;
    logic dev_d_low  = 1'b0;
    bit   dev_ack    = 1'b1;
    bit   dev_glitch = 1'b0;

    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    always #5 clk = ~clk;

    ps2_tx #(.RTS_CYCLES(RTS)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .ack_err      (ack_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Device model: times the inhibit, clocks 11 bits, samples on rising edges
    initial begin
        logic [10:0] f;
        int cnt;
        int rem;
        forever begin
            @(negedge clk);
            if (ps2c === 1'b0 && !dev_c_low) begin
                cnt = 1;
                forever begin
                    @(negedge clk);
                    if (ps2c !== 1'b0) break;
                    cnt++;
                end
                if (ps2d === 1'b0) begin
                    f    = '0;
                    f[0] = ps2d;
                    repeat (HALF) @(negedge clk);
                    for (int i = 1; i <= 11; i++) begin
                        dev_c_low = 1'b1;
                        repeat (HALF) @(negedge clk);
                        dev_c_low = 1'b0;
                        repeat (2) @(negedge clk);
                        rem = HALF - 2;
                        if (i <= 10) f[i] = ps2d;
                        if (i == 3 && dev_glitch) begin
                            dev_c_low = 1'b1;
                            repeat (3) @(negedge clk);
                            dev_c_low = 1'b0;
                            repeat (12) @(negedge clk);
                            chk("glitch_n_reg", 32'(dut.n_reg), 32'd6);
                            rem = rem - 15;
                        end
                        if (i == 10) begin
                            cap_q.push_back('{frame: f, rts: cnt});
                            dev_d_low = dev_ack;
                        end
                        repeat (rem) @(negedge clk);
                    end
                    dev_d_low = 1'b0;
                end
            end
        end
    end

    // Monitor: every done tick retires one expected frame
    initial begin
        exp_t e;
        cap_t c;
        forever begin
            @(negedge clk);
            if (tx_done_tick === 1'b1) begin
                n_ticks++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_tick", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    if (cap_q.size() == 0) begin
                        chk("no_capture", 32'd0, 32'd1);
                    end else begin
                        c = cap_q.pop_front();
                        chk("frame_bits", 32'(c.frame), 32'(e.frame));
                        chk("rts_low_cycles", 32'(c.rts), 32'(RTS));
                    end
                    chk("ack_err", 32'(ack_err), 32'(e.ack));
                    chk("idle_at_tick", 32'(tx_idle), 32'd0);
                    @(negedge clk);
                    chk("tick_one_cycle", 32'(tx_done_tick), 32'd0);
                    chk("idle_after_tick", 32'(tx_idle), 32'd1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic [10:0] ef,
                        input logic ea, input bit ack, input bit glitch,
                        input bit extra_wr);
        int t0;
        dev_ack    = ack;
        dev_glitch = glitch;
        t0 = n_ticks;
        @(posedge clk);
        #1;
        din    = b;
        wr_ps2 = 1'b1;
        sb_q.push_back('{frame: ef, ack: ea});
        @(posedge clk);
        #1;
        wr_ps2 = 1'b0;
        din    = ~b;
        if (extra_wr) begin
            repeat (RTS + HALF + 300) @(posedge clk);
            #1;
            din    = 8'hFF;
            wr_ps2 = 1'b1;
            @(posedge clk);
            #1;
            wr_ps2 = 1'b0;
        end
        for (int i = 0; i < 4000 && n_ticks == t0; i++)
            @(posedge clk);
        chk("frame_done", 32'(n_ticks != t0), 32'd1);
        repeat (100) @(posedge clk);
        #1;
        chk("idle_between", 32'(tx_idle), 32'd1);
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_tx_idle", 32'(tx_idle), 32'd1);
        chk("rst_tick", 32'(tx_done_tick), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        chk("rst_ps2c", 32'(ps2c), 32'd1);
        chk("rst_ps2d", 32'(ps2d), 32'd1);
        chk("rst_n_reg", 32'(dut.n_reg), 32'd0);

        // Abandon a frame during the inhibit phase
        @(posedge clk);
        #1;
        din    = 8'hF4;
        wr_ps2 = 1'b1;
        @(posedge clk);
        #1;
        wr_ps2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rts_ps2c", 32'(ps2c), 32'd0);
        chk("mid_rts_idle", 32'(tx_idle), 32'd0);
        t0 = n_ticks;
        reset = 1'b1;
        #1;
        chk("mid_rst_ps2c", 32'(ps2c), 32'd1);
        chk("mid_rst_idle", 32'(tx_idle), 32'd1);
        chk("mid_rst_ps2d", 32'(ps2d), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (200) @(posedge clk);
        chk("mid_rst_no_tick", 32'(n_ticks), 32'(t0));

        send(8'hF4, 11'b1_0_11110100_0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h00, 11'b1_1_00000000_0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h55, 11'b1_1_01010101_0, ACK_CHK, 1'b0, 1'b0, 1'b0);
        send(8'hA7, 11'b1_0_10100111_0, 1'b0, 1'b1, 1'b1, 1'b1);

        repeat (50) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("cap_drained", 32'(cap_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter for the mouse controller. It sends one command byte (for example 0xF4 "enable data reporting" or 0xFF "reset") to the mouse over the shared open-drain ps2c/ps2d lines. It performs the request-to-send sequence, shifts out the frame on device-generated clock edges, and captures the device's acknowledge bit. It sits beside the PS/2 receiver on the same two pins; its `tx_idle` output drives the receiver's `rx_en`, so the two directions never overlap.

## Interface
- `RTS_CYCLES`, default 5000: number of clk cycles ps2c is held low to inhibit the device (100 µs at 50 MHz). Must be ≥ 2.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr_ps2` in 1: single-cycle start strobe; sampled only when `tx_idle`=1.
- `din` in 8: command byte, captured in the cycle `wr_ps2` is accepted.
- `ps2c` inout 1: PS/2 clock, open-drain; driven 0 or released to Z, never driven 1.
- `ps2d` inout 1: PS/2 data, open-drain; same rule as `ps2c`.
- `tx_idle` out 1: 1 when in `idle`; connect to the receiver's `rx_en`.
- `tx_done_tick` out 1: one-cycle pulse when the frame is complete.
- `ack_err` out 1: registered; 1 if the last frame was not acknowledged (see Configuration).

## Operation
- Clock filter:
  - 8-bit shift register samples ps2c every clk.
  - Filtered clock goes to 1 when all 8 samples are 1, goes to 0 when all 8 are 0, and otherwise holds.
  - `fall_edge` = filtered value 1 → next value 0.
- Frame register: `b_reg[8:0]` = {odd parity, din}, where parity = ~^din. Bit 0 is sent first.
- Bit counter: `n_reg`, 4 bits. Inhibit counter: `c_reg`, wide enough for `RTS_CYCLES`.
- FSM states and line control (cz = ps2c driven 0, dz = ps2d driven 0):
  - `idle`: both lines released. On `wr_ps2`: load `b_reg`, set `c_reg` = RTS_CYCLES-1, go to `rts`.
  - `rts`: cz=1. Decrement `c_reg`; when it reaches 0, go to `start`.
  - `start`: ps2c released, dz=1 (start bit). On `fall_edge`: set `n_reg`=8, go to `data`.
  - `data`: ps2d driven 0 when `b_reg[0]`=0, released when 1. On each `fall_edge`: `b_reg` shifts right. If `n_reg`==0 go to `stop`, else `n_reg`−1.
  - `stop`: both lines released (stop bit = 1). On `fall_edge` (11th device clock): sample ps2d as the ack bit and go to `done`.
  - `done`: wait until the filtered ps2c is 1, then pulse `tx_done_tick` and go to `idle`.
- Falling-edge numbering from the device:
  - F1 ends the start bit.
  - F2–F9 present d1..d7 and parity. d0 is presented on entry to `data`.
  - F10 releases the line for the stop bit.
  - F11 samples the ack.
- `wr_ps2` outside `idle` is ignored. `din` is not re-sampled.
- No timeout: a silent device holds the FSM in `start` or `data` until `reset`.

## Timing
- Reset values: FSM = `idle`, `tx_idle`=1, `tx_done_tick`=0, `ack_err`=0. Both lines released, filter register and filtered clock = 0, `b_reg`/`n_reg`/`c_reg` = 0.
- Reset mid-frame: lines are released in the same cycle (async). Frame is abandoned with no `tx_done_tick`.
- `wr_ps2` accepted at edge k: `tx_idle`=0 and ps2c driven low from edge k+1, for exactly RTS_CYCLES cycles. ps2d goes low and ps2c is released on the same edge.
- Line-enable outputs are registered (decoded from registered state and `b_reg`). They change only on a clk edge.
- Data changes at most one clk after `fall_edge` is detected. This is well inside the PS/2 half-period (≥ 30 µs).
- `tx_done_tick` is asserted in the same cycle the FSM returns to `idle`. `tx_idle` rises on the next edge.
- `ack_err` updates on the F11 edge and holds until the next F11 or reset.

## Configuration
- `PS2_TX_ACK_CHECK_EN` defined: `ack_err` is loaded with the sampled ps2d at F11 (1 = no ack, line high).
- `PS2_TX_ACK_CHECK_EN` undefined: no ack register; `ack_err` is tied to 0. F11 is still waited for, so frame timing is identical.

## Test plan
- Reset mid-frame:
  - Stimulus: assert `reset` during `rts`.
  - Response: ps2c released the same cycle, `tx_idle`=1, no `tx_done_tick`.
- Send 0xF4 to a device model (RTS_CYCLES=50, clock period 80 clk):
  - ps2c low for exactly 50 cycles.
  - Bits sampled on rising edges = 0, 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - One `tx_done_tick` after F11; `ack_err`=0.
- Send 0x00:
  - Parity bit = 1.
  - 11 falling edges consumed, then `tx_idle` returns to 1.
- Device withholds the ack (ps2d high at F11):
  - Macro defined: `ack_err`=1.
  - Macro undefined: `ack_err`=0.
  - `tx_done_tick` pulses in both builds.
- `wr_ps2` with din=0xFF pulsed again during `data`:
  - Ignored; the frame in flight still transmits its original byte.
- Glitch on ps2c (3-cycle low pulse) during `data`:
  - No shift; `n_reg` is unchanged.
